cache_axi_bridge: RTL

Converts the cache-line refill/writeback handshake (128-bit lines, 4 words) into AXI4 32-bit, 4-beat INCR bursts. Sits directly downstream of the I-cache and D-cache line ports as the slave side of `AXI_Bus_Interface`, and drives the core's AXI master port. Independent read and write engines allow a refill and a writeback to be in flight at the same time.

---
 rtl/cache_axi_bridge_if.sv | 48 ++++
 rtl/cache_axi_bridge.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/cache_axi_bridge_if.sv
// AXI4 32-bit bus between the cache line bridge (master) and the memory side (slave).
interface cache_axi_bridge_if;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arvalid, rready,
           awid, awaddr, awlen, awsize, awburst, awvalid,
           wdata, wstrb, wlast, wvalid, bready,
    input  arready, rid, rdata, rresp, rlast, rvalid,
           awready, wready, bid, bresp, bvalid
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
           awid, awaddr, awlen, awsize, awburst, awvalid,
           wdata, wstrb, wlast, wvalid, bready,
    output arready, rid, rdata, rresp, rlast, rvalid,
           awready, wready, bid, bresp, bvalid
  );
endinterface

// File: rtl/cache_axi_bridge.sv
// 128-bit cache line refill/writeback to AXI4 32-bit 4-beat INCR bursts, independent read/write engines.
// Optional CACHE_AXI_POSTED_WR_EN: early writeback ack plus refill hold-off on a matching pending line.
module cache_axi_bridge #(
  parameter logic [3:0] AR_ID = 4'h0,
  parameter logic [3:0] AW_ID = 4'h1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rd_req,
  input  logic [31:0]  rd_addr,
  output logic         rd_rdy,
  output logic         ret_valid,
  output logic [127:0] ret_data,
  input  logic         wr_req,
  input  logic [31:0]  wr_addr,
  input  logic [127:0] wr_data,
  output logic         wr_rdy,
  output logic         wr_valid,
  cache_axi_bridge_if.master axi
);
  typedef enum logic [1:0] {R_IDLE, R_AR, R_DATA, R_RET} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_AW, W_DATA, W_B} w_state_t;

  r_state_t     r_state, r_next;
  w_state_t     w_state, w_next;
  logic [31:0]  araddr_q, awaddr_q;
  logic [1:0]   r_cnt, w_cnt;
  logic [127:0] w_line;
  logic         rd_idle, wr_idle, rd_block, wr_valid_q;
  logic         unused_in;

  assign unused_in = ^{axi.rid, axi.rresp, axi.rlast, axi.bid, axi.bresp,
                       rd_addr[3:0], wr_addr[3:0]};

  assign axi.arid    = AR_ID;
  assign axi.arlen   = 8'd3;
  assign axi.arsize  = 3'd2;
  assign axi.arburst = 2'b01;
  assign axi.araddr  = araddr_q;
  assign axi.awid    = AW_ID;
  assign axi.awlen   = 8'd3;
  assign axi.awsize  = 3'd2;
  assign axi.awburst = 2'b01;
  assign axi.awaddr  = awaddr_q;
  assign axi.wstrb   = 4'hF;
  assign axi.wdata   = w_line[{w_cnt, 5'd0} +: 32];

`ifdef CACHE_AXI_POSTED_WR_EN
  // A refill of the line still draining to memory would read stale data.
  assign rd_block = (w_state != W_IDLE) && (rd_addr[31:4] == awaddr_q[31:4]);
`else
  assign rd_block = 1'b0;
`endif

  assign rd_rdy   = rd_idle & ~rd_block;
  assign wr_rdy   = wr_idle;
  assign wr_valid = wr_valid_q;

  // read engine
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= R_IDLE;
    else     r_state <= r_next;

  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:  if (rd_req && rd_rdy) r_next = R_AR;
      R_AR:    if (axi.arready) r_next = R_DATA;
      R_DATA:  if (axi.rvalid && r_cnt == 2'd3) r_next = R_RET;
      default: r_next = R_IDLE;
    endcase
  end

  always_comb begin
    rd_idle     = 1'b0;
    axi.arvalid = 1'b0;
    axi.rready  = 1'b0;
    ret_valid   = 1'b0;
    case (r_state)
      R_IDLE:  rd_idle     = 1'b1;
      R_AR:    axi.arvalid = 1'b1;
      R_DATA:  axi.rready  = 1'b1;
      default: ret_valid   = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      araddr_q <= '0;
      r_cnt    <= '0;
      ret_data <= '0;
    end else begin
      if (r_state == R_IDLE && rd_req && rd_rdy) begin
        araddr_q <= {rd_addr[31:4], 4'b0};
        r_cnt    <= '0;
      end
      if (r_state == R_DATA && axi.rvalid) begin
        ret_data[{r_cnt, 5'd0} +: 32] <= axi.rdata;
        r_cnt <= r_cnt + 2'd1;
      end
    end

  // write engine
  always_ff @(posedge clk or posedge rst)
    if (rst) w_state <= W_IDLE;
    else     w_state <= w_next;

  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE:  if (wr_req) w_next = W_AW;
      W_AW:    if (axi.awready) w_next = W_DATA;
      W_DATA:  if (axi.wready && w_cnt == 2'd3) w_next = W_B;
      default: if (axi.bvalid) w_next = W_IDLE;
    endcase
  end

  always_comb begin
    wr_idle     = 1'b0;
    axi.awvalid = 1'b0;
    axi.wvalid  = 1'b0;
    axi.wlast   = 1'b0;
    axi.bready  = 1'b0;
    case (w_state)
      W_IDLE:  wr_idle     = 1'b1;
      W_AW:    axi.awvalid = 1'b1;
      W_DATA:  begin
        axi.wvalid = 1'b1;
        axi.wlast  = (w_cnt == 2'd3);
      end
      default: axi.bready  = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      awaddr_q   <= '0;
      w_line     <= '0;
      w_cnt      <= '0;
      wr_valid_q <= 1'b0;
    end else begin
      if (w_state == W_IDLE && wr_req) begin
        awaddr_q <= {wr_addr[31:4], 4'b0};
        w_line   <= wr_data;
        w_cnt    <= '0;
      end
      if (w_state == W_DATA && axi.wready) w_cnt <= w_cnt + 2'd1;
`ifdef CACHE_AXI_POSTED_WR_EN
      wr_valid_q <= (w_state == W_IDLE) && wr_req;
`else
      wr_valid_q <= (w_state == W_B) && axi.bvalid;
`endif
    end
endmodule
